sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_feeder.sv | 115 +++++++++++
 tb/tb_sa_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_feeder.sv
// Operand feeder for a SIZE x SIZE systolic array: captures an A/B matrix pair and
// streams the skewed west (A rows) and north (B columns) edge vectors one beat at a time.
module sa_feeder #(
  parameter int SIZE       = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] A,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] B,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE*DATA_WIDTH-1:0]      a_edge,
  output logic [SIZE*DATA_WIDTH-1:0]      b_edge,
  output logic                            first,
  output logic                            last,
  output logic                            busy
);

  localparam int MW        = SIZE*SIZE*DATA_WIDTH;
  localparam int LW        = SIZE*DATA_WIDTH;
  localparam int LAST_BEAT = 2*SIZE - 2;
  localparam int TW        = (LAST_BEAT > 0) ? $clog2(LAST_BEAT + 1) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(LAST_BEAT);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic [MW-1:0]   a_reg;
  logic [MW-1:0]   b_reg;
  logic [TW-1:0]   t;

  logic [MW-1:0]   src_a;
  logic [MW-1:0]   src_b;
  logic [TW-1:0]   beat_nxt;
  logic [LW-1:0]   a_nxt;
  logic [LW-1:0]   b_nxt;

  // Edge vectors for the beat about to be registered: beat 0 straight from the
  // inputs on capture, otherwise beat t+1 from the held operands.
  always_comb begin
    int unsigned bn;
    src_a    = (state == IDLE) ? A : a_reg;
    src_b    = (state == IDLE) ? B : b_reg;
    beat_nxt = (state == IDLE) ? '0 : t + 1'b1;
    bn       = 32'(beat_nxt);
    a_nxt    = '0;
    b_nxt    = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (bn >= i && (bn - i) < SIZE) begin
        a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = src_a[(i*SIZE + (bn - i))*DATA_WIDTH +: DATA_WIDTH];
        b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = src_b[((bn - i)*SIZE + i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      a_edge    <= '0;
      b_edge    <= '0;
      first     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            t         <= '0;
            state     <= STREAM;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            a_edge    <= a_nxt;
            b_edge    <= b_nxt;
            first     <= 1'b1;
            last      <= (LAST_BEAT == 0);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (t == LAST_T) begin
              state     <= IDLE;
              t         <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              a_edge    <= '0;
              b_edge    <= '0;
              first     <= 1'b0;
              last      <= 1'b0;
            end else begin
              t      <= beat_nxt;
              a_edge <= a_nxt;
              b_edge <= b_nxt;
              first  <= 1'b0;
              last   <= (beat_nxt == LAST_T);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: the driver offers matrix pairs, the monitor predicts
// every beat from the matrices at acceptance and checks outputs on each falling edge.
module tb_sa_feeder;

  localparam int S  = 2;
  localparam int DW = 8;
  localparam int LW = S*DW;
  localparam int MW = S*S*DW;
  localparam int NB = 2*S - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] A;
  logic [MW-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] a_edge;
  logic [LW-1:0] b_edge;
  logic          first;
  logic          last;
  logic          busy;

  always #5 clk = ~clk;

  sa_feeder #(.SIZE(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .a_edge(a_edge), .b_edge(b_edge), .first(first), .last(last), .busy(busy)
  );

  typedef struct packed {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          first;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] cur_a[S][S];
  logic [DW-1:0] cur_b[S][S];
  int            checks = 0;
  int            passed = 0;
  bit            mon_en = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  // Beat t of a matrix pair: west lane i carries row i shifted right by i,
  // north lane j carries column j shifted down by j.
  function automatic beat_t model_beat(input int t);
    beat_t e;
    e = '0;
    for (int i = 0; i < S; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < S) begin
        e.a[i*DW +: DW] = cur_a[i][k];
        e.b[i*DW +: DW] = cur_b[k][i];
      end
    end
    e.first = (t == 0);
    e.last  = (t == NB - 1);
    return e;
  endfunction

  task automatic pack();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        A[(r*S + c)*DW +: DW] = cur_a[r][c];
        B[(r*S + c)*DW +: DW] = cur_b[r][c];
      end
  endtask

  task automatic spec_mats();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        cur_a[r][c] = DW'(r*S + c + 1);
        cur_b[r][c] = DW'(r*S + c + 1);
      end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        cur_a[r][c] = DW'($urandom);
        cur_b[r][c] = DW'($urandom);
      end
  endtask

  task automatic offer(input bit hold);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    pack();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!out_valid && in_ready && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare what is presented now, then advance the expectation by what
  // the coming rising edge will do (reset, beat completion, capture).
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(sb.size() == 0));
      chk("busy",      64'(busy),      64'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        chk("a_edge", 64'(a_edge), 64'(sb[0].a));
        chk("b_edge", 64'(b_edge), 64'(sb[0].b));
        chk("first",  64'(first),  64'(sb[0].first));
        chk("last",   64'(last),   64'(sb[0].last));
      end else if (!out_valid) begin
        chk("idle_a_edge", 64'(a_edge), 64'(0));
        chk("idle_b_edge", 64'(b_edge), 64'(0));
        chk("idle_first",  64'(first),  64'(0));
        chk("idle_last",   64'(last),   64'(0));
      end
      if (rst === 1'b1) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready)
          for (int t = 0; t < NB; t++) sb.push_back(model_beat(t));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    // Offer a pair while reset is held: nothing may be captured.
    spec_mats(); pack(); in_valid = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0; rst = 1'b0;

    // Basic stream.
    spec_mats(); offer(1'b0); wait_idle();

    // Stall three cycles on beat 1.
    offer(1'b0);
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_idle();

    // New operands offered mid-stream are ignored until the stream finishes.
    offer(1'b1);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) cur_a[r][c] = 8'd9;
    offer(1'b0); wait_idle();

    // Reset during beat 1 abandons the matrix.
    spec_mats(); offer(1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    wait_idle();

    // Back-to-back pairs with in_valid held.
    rand_mats(); offer(1'b1);
    rand_mats(); offer(1'b0);
    wait_idle();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    repeat (40) begin
      rand_mats();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      offer(bit'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk); #2; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
